// File: rtl/booth_mul32_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: widths, FSM
// encoding, iteration count and the Booth pair decoder.
package booth_mul32_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;
  localparam int ITER   = 32;
  localparam int CNT_W  = 5;

  // Counter value during the final iteration; the FSM leaves EXEC once it completes.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'b00,
    BOOTH_ADD = 2'b01,
    BOOTH_SUB = 2'b10
  } booth_op_t;

  // Radix-2 Booth recoding of {current LSB, previous LSB}.
  function automatic booth_op_t booth_decode(input logic [1:0] pair);
    booth_op_t op;
    case (pair)
      2'b01:   op = BOOTH_ADD;
      2'b10:   op = BOOTH_SUB;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_mul32_cla64.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups, with the group
// carries chained through group generate/propagate terms.
module cla64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        ci,
  output logic [63:0] s,
  output logic        co
);

  logic [63:0] w_g;
  logic [63:0] w_p;
  logic [63:0] w_c;
  logic [16:0] w_gc;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Per-group carry lookahead, then group-level carry into the next group.
  always_comb begin
    w_c     = '0;
    w_gc    = '0;
    w_gc[0] = ci;
    for (int k = 0; k < 16; k++) begin
      w_c[4*k]   = w_gc[k];
      w_c[4*k+1] = w_g[4*k] | (w_p[4*k] & w_gc[k]);
      w_c[4*k+2] = w_g[4*k+1] | (w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_c[4*k+3] = w_g[4*k+2] | (w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (w_p[4*k+2] & w_p[4*k+1] & w_p[4*k] & w_gc[k]);
      w_gc[k+1]  = w_g[4*k+3] | (w_p[4*k+3] & w_g[4*k+2])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                 | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k])
                 | (&w_p[4*k +: 4] & w_gc[k]);
    end
  end

  assign s  = w_p ^ w_c;
  assign co = w_gc[16];

endmodule

// File: rtl/booth_mul32.sv
// Sequential radix-2 Booth multiplier, signed 32x32 -> 64, one iteration
// per clock. The upper half of the product register is the accumulator and
// the lower half initially holds the multiplier, shifted out one bit per cycle.
//
// Handshake: op_start is a one-edge request taken whenever the block is in
// IDLE or DONE and op_clear is low; in EXEC it is ignored. op_done is a level
// that marks result valid and holds until op_clear or the next accepted
// op_start. op_clear aborts in any state and wins over op_start.
module booth_mul32
  import booth_mul32_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              op_start,
  input  logic              op_clear,
  input  logic [OP_W-1:0]   multiplicand,
  input  logic [OP_W-1:0]   multiplier,
  output logic [PROD_W-1:0] result,
  output logic              busy,
  output logic              op_done,
  output state_t            dbg_state
);

  state_t             r_state;
  state_t             w_next_state;
  logic [OP_W-1:0]    r_m;
  logic [PROD_W-1:0]  r_result;
  logic               r_q1;
  logic [CNT_W-1:0]   r_count;

  booth_op_t          w_op;
  logic [PROD_W-1:0]  w_a;
  logic [PROD_W-1:0]  w_b;
  logic               w_ci;
  logic [PROD_W-1:0]  w_sum;
  logic               w_co;
  logic               w_accept;
  logic               w_unused_sum_hi;

  // Booth select and adder operand muxing around the single adder.
  always_comb begin
    w_op = booth_decode({r_result[0], r_q1});
    w_a  = {{OP_W{r_result[PROD_W-1]}}, r_result[PROD_W-1:OP_W]};
    w_b  = '0;
    w_ci = 1'b0;
    case (w_op)
      BOOTH_ADD: w_b = {{OP_W{r_m[OP_W-1]}}, r_m};
      BOOTH_SUB: begin
        w_b  = ~{{OP_W{r_m[OP_W-1]}}, r_m};
        w_ci = 1'b1;
      end
      default: w_b = '0;
    endcase
  end

  cla64 u_cla64 (
    .a  (w_a),
    .b  (w_b),
    .ci (w_ci),
    .s  (w_sum),
    .co (w_co)
  );

  // Only bit 32 of the sign-extended sum is needed as the shift-in bit.
  assign w_unused_sum_hi = ^{w_sum[PROD_W-1:OP_W+1], w_co};

  assign w_accept = op_start && !op_clear && (r_state != ST_EXEC);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: clear first, then start acceptance, then iteration end.
  always_comb begin
    w_next_state = r_state;
    if (op_clear) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: if (op_start) w_next_state = ST_EXEC;
        ST_EXEC:          if (r_count == LAST_CNT) w_next_state = ST_DONE;
        default:          w_next_state = ST_IDLE;
      endcase
    end
  end

  // Datapath: operand capture, Booth add/shift step, or clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m      <= '0;
      r_result <= '0;
      r_q1     <= 1'b0;
      r_count  <= '0;
    end else if (op_clear) begin
      r_result <= '0;
      r_q1     <= 1'b0;
      r_count  <= '0;
    end else if (r_state == ST_EXEC) begin
      // Bit 32 of the 33-bit sum keeps the sign correct on 32-bit overflow.
      r_result <= {w_sum[OP_W], w_sum[OP_W-1:0], r_result[OP_W-1:1]};
      r_q1     <= r_result[0];
      r_count  <= r_count + CNT_W'(1);
    end else if (w_accept) begin
      r_m      <= multiplicand;
      r_result <= {{OP_W{1'b0}}, multiplier};
      r_q1     <= 1'b0;
      r_count  <= '0;
    end
  end

  assign result    = r_result;
  assign busy      = (r_state == ST_EXEC);
  assign op_done   = (r_state == ST_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_booth_mul32.sv
// Bench for booth_mul32: directed corner products, start-ignore, clear and
// reset aborts, back-to-back starts and randomized operands scored against
// a plain signed-multiply model.
module tb_booth_mul32;
  import booth_mul32_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_start;
  logic        op_clear;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [63:0] result;
  logic        busy;
  logic        op_done;
  state_t      dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];

  booth_mul32 dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_start     (op_start),
    .op_clear     (op_clear),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .result       (result),
    .busy         (busy),
    .op_done      (op_done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // busy and op_done are mutually exclusive at every sample point.
  always @(negedge clk) begin
    if (reset_n === 1'b1) check_eq("busy_done_excl", 64'(busy & op_done), 64'd0);
  end

  // Reference: plain signed multiplication.
  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint p;
    p = longint'($signed(m)) * longint'($signed(q));
    return p;
  endfunction

  // ---------------- drivers ----------------
  task automatic start_op(input logic [31:0] m, input logic [31:0] q);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    op_start     = 1'b1;
    @(posedge clk);
    #1;
    op_start     = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    check_eq("busy_after_start", 64'(busy), 64'd1);
  endtask

  // Counts rising edges until op_done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (op_done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Latency is counted in edges after the accepting edge: done on the 32nd,
  // i.e. edge 33 when the accepting edge is numbered 1.
  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input logic [63:0] e);
    int n;
    exp_q.push_back(e);
    start_op(m, q);
    wait_done(n);
    check_eq({tag, "_lat"}, 64'(n), 64'd32);
    check_eq(tag, result, exp_q.pop_front());
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [4];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h8000_0000;
    corners[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [63:0] held;
    logic [31:0] rm;
    logic [31:0] rq;

    reset_n      = 1'b0;
    op_start     = 1'b0;
    op_clear     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_result", result, 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(op_done), 64'd0);
    check_eq("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    // Directed products.
    run_op("p3x5",     32'd3,          32'd5,          64'h0000_0000_0000_000F);
    run_op("pm3x5",    32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1);
    run_op("pm7xm6",   32'hFFFF_FFF9,  32'hFFFF_FFFA,  64'h0000_0000_0000_002A);
    run_op("pminxmin", 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
    run_op("pmaxxmin", 32'h7FFF_FFFF,  32'h8000_0000,  64'hC000_0000_8000_0000);

    // Result holds in DONE.
    held = result;
    repeat (5) @(posedge clk);
    #1;
    check_eq("done_hold_result", result, held);
    check_eq("done_hold_flag", 64'(op_done), 64'd1);

    // Back-to-back start from DONE.
    run_op("b2b_2xm1", 32'd2, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);

    // op_start during EXEC is ignored.
    start_op(32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    op_start     = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    check_eq("ign_busy", 64'(busy), 64'd1);
    wait_done(n);
    check_eq("ign_lat", 64'(n + 10), 64'd32);
    check_eq("ign_result", result, 64'h0000_0000_0000_000F);

    // Asynchronous reset mid-EXEC, then start on first edge after release.
    start_op(32'd11, 32'd13);
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("arst_result", result, 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_done", 64'(op_done), 64'd0);
    repeat (2) @(negedge clk);
    reset_n      = 1'b1;
    multiplicand = 32'd2;
    multiplier   = 32'd3;
    op_start     = 1'b1;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    check_eq("post_rst_accept", 64'(busy), 64'd1);
    wait_done(n);
    check_eq("post_rst_lat", 64'(n), 64'd32);
    check_eq("post_rst_result", result, 64'd6);

    // Synchronous clear mid-EXEC.
    start_op(32'd123, 32'd456);
    repeat (19) @(posedge clk);
    @(negedge clk);
    op_clear = 1'b1;
    op_start = 1'b1;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
    op_start = 1'b0;
    check_eq("clr_exec_result", result, 64'd0);
    check_eq("clr_exec_state", 64'(dbg_state), 64'(ST_IDLE));
    check_eq("clr_exec_busy", 64'(busy), 64'd0);

    // Synchronous clear in DONE.
    run_op("pre_clr", 32'd100, 32'hFFFF_FF9C, ref_mul(32'd100, 32'hFFFF_FF9C));
    @(negedge clk);
    op_clear = 1'b1;
    @(posedge clk);
    #1;
    op_clear = 1'b0;
    check_eq("clr_done_result", result, 64'd0);
    check_eq("clr_done_flag", 64'(op_done), 64'd0);

    // Randomized operands against the model.
    for (int i = 0; i < 20; i++) begin
      rm = pick_operand();
      rq = pick_operand();
      run_op("rand", rm, rq, ref_mul(rm, rq));
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
